// File: rtl/cnn.sv
// cnn: single-layer 2D convolution engine.
// Holds NUM_FEATURES kernels of KERNEL_SIZE x KERNEL_SIZE signed 2-bit weights and
// convolves a parallel-presented signed 2-bit image with all of them at once.
// One output position per cycle is produced for every feature map (no padding).
// Ports:
//   clk                 - clock, rising edge
//   rst_cnn             - async active-low reset of FSM, counters and outputs
//   rst_weights         - async active-low clear of the weight memory
//   image_input         - image, [row][col], signed 2-bit elements
//   weights_input       - one flattened kernel, index r*K+c
//   feature_writeAddr   - kernel slot written when feature_WrEn is low
//   feature_WrEn        - active-low weight write enable
//   convolution_enable  - active-low run request / pause when high in CONV
//   outfmap             - registered output maps [feature][row][col]
//   done                - high once every output position has been written
module cnn #(
  parameter int unsigned IMAGE_WIDTH  = 12,
  parameter int unsigned IMAGE_HEIGHT = 12,
  parameter int unsigned NUM_FEATURES = 2,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned STRIDE       = 1,
  parameter int unsigned DATA_WIDTH   = 8,
  localparam int unsigned OW = (IMAGE_WIDTH - KERNEL_SIZE) / STRIDE + 1,
  localparam int unsigned OH = (IMAGE_HEIGHT - KERNEL_SIZE) / STRIDE + 1,
  localparam int unsigned AW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  localparam int unsigned KK = KERNEL_SIZE * KERNEL_SIZE
) (
  input  logic                         clk,
  input  logic                         rst_cnn,
  input  logic                         rst_weights,
  input  logic signed [1:0]            image_input [IMAGE_HEIGHT][IMAGE_WIDTH],
  input  logic signed [1:0]            weights_input [KK],
  input  logic [AW-1:0]                feature_writeAddr,
  input  logic                         feature_WrEn,
  input  logic                         convolution_enable,
  output logic signed [DATA_WIDTH-1:0] outfmap [NUM_FEATURES][OH][OW],
  output logic                         done
);

  localparam int unsigned RW  = (OH > 1) ? $clog2(OH) : 1;
  localparam int unsigned CW  = (OW > 1) ? $clog2(OW) : 1;
  localparam int unsigned IRW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned ICW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                       state_q;
  logic [RW-1:0]                row_q;
  logic [CW-1:0]                col_q;
  logic signed [1:0]            weights_q [NUM_FEATURES][KK];
  logic signed [DATA_WIDTH-1:0] conv_c [NUM_FEATURES];

  // Weight memory: whole-kernel writes, cleared only by rst_weights.
  always_ff @(posedge clk or negedge rst_weights) begin
    if (!rst_weights) begin
      weights_q <= '{default: '0};
    end else if (!feature_WrEn && (32'(feature_writeAddr) < NUM_FEATURES)) begin
      weights_q[feature_writeAddr] <= weights_input;
    end
  end

  // Window MAC per feature as a sign-extended add chain; wraps at DATA_WIDTH.
  for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_feat
    logic signed [DATA_WIDTH-1:0] psum [KK];
    for (genvar i = 0; i < KK; i++) begin : g_tap
      localparam int unsigned TR = i / KERNEL_SIZE;
      localparam int unsigned TC = i % KERNEL_SIZE;
      logic signed [DATA_WIDTH-1:0] prod;
      assign prod = DATA_WIDTH'(weights_q[f][i]) *
                    DATA_WIDTH'(image_input[IRW'(32'(row_q) * STRIDE + TR)]
                                           [ICW'(32'(col_q) * STRIDE + TC)]);
      if (i == 0) begin : g_first
        assign psum[i] = prod;
      end else begin : g_next
        assign psum[i] = psum[i-1] + prod;
      end
    end
    assign conv_c[f] = psum[KK-1];
  end

  // Control FSM with registered outputs; enable high in CONV freezes everything.
  always_ff @(posedge clk or negedge rst_cnn) begin
    if (!rst_cnn) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      done    <= 1'b0;
      outfmap <= '{default: '0};
    end else begin
      case (state_q)
        IDLE: begin
          if (!convolution_enable) begin
            state_q <= CONV;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        CONV: begin
          if (!convolution_enable) begin
            for (int f = 0; f < NUM_FEATURES; f++) begin
              outfmap[AW'(f)][row_q][col_q] <= conv_c[AW'(f)];
            end
            if (col_q == CW'(OW - 1)) begin
              col_q <= '0;
              if (row_q == RW'(OH - 1)) begin
                row_q   <= '0;
                state_q <= DONE;
                done    <= 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (convolution_enable) begin
            state_q <= IDLE;
            done    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn.sv
// tb_cnn: directed self-checking bench for cnn (default 12x12 image, 2 features, 3x3).
module tb_cnn;

  localparam int IW = 12;
  localparam int IH = 12;
  localparam int NF = 2;
  localparam int K  = 3;
  localparam int OW = 10;
  localparam int OH = 10;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst_cnn;
  logic                 rst_weights;
  logic signed [1:0]    image_input [IH][IW];
  logic signed [1:0]    weights_input [K*K];
  logic [0:0]           feature_writeAddr;
  logic                 feature_WrEn;
  logic                 convolution_enable;
  logic signed [DW-1:0] outfmap [NF][OH][OW];
  logic                 done;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_m [NF][OH][OW];
  int w0 [K*K] = '{1, -1, 1, -1, 1, -1, 1, -1, 1};
  int w1 [K*K] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};

  cnn dut (
    .clk                (clk),
    .rst_cnn            (rst_cnn),
    .rst_weights        (rst_weights),
    .image_input        (image_input),
    .weights_input      (weights_input),
    .feature_writeAddr  (feature_writeAddr),
    .feature_WrEn       (feature_WrEn),
    .convolution_enable (convolution_enable),
    .outfmap            (outfmap),
    .done               (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_maps(input string tag);
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < OH; r++)
        for (int c = 0; c < OW; c++)
          chk($sformatf("%s map%0d[%0d][%0d]", tag, f, r, c),
              int'(outfmap[f][r][c]), exp_m[f][r][c]);
  endtask

  // mode 0: constant v; 1: checkerboard; 2: single pixel at [5][5]
  task automatic set_image(input int mode, input int v);
    for (int i = 0; i < IH; i++)
      for (int j = 0; j < IW; j++) begin
        if (mode == 0)      image_input[i][j] = 2'(v);
        else if (mode == 1) image_input[i][j] = (((i + j) % 2) == 0) ? 2'sd1 : -2'sd1;
        else                image_input[i][j] = (i == 5 && j == 5) ? 2'sd1 : 2'sd0;
      end
  endtask

  task automatic set_exp_const(input int v0, input int v1);
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++) begin
        exp_m[0][r][c] = v0;
        exp_m[1][r][c] = v1;
      end
  endtask

  task automatic load_w(input int slot, input int w [K*K]);
    @(negedge clk);
    feature_writeAddr = 1'(slot);
    for (int i = 0; i < K*K; i++) weights_input[i] = 2'(w[i]);
    feature_WrEn = 1'b0;
    @(negedge clk);
    feature_WrEn = 1'b1;
  endtask

  // Start a run, optionally pause, check latency and DONE hold, then return to IDLE.
  task automatic run(input string tag, input int pause_at, input int pause_len, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    convolution_enable = 1'b0;
    while (done !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (pause_len > 0 && n == pause_at) convolution_enable = 1'b1;
      if (pause_len > 0 && n == pause_at + pause_len) convolution_enable = 1'b0;
    end
    chk({tag, " latency"}, n - 1, exp_lat);
    @(posedge clk);
    #1;
    chk({tag, " done hold"}, int'(done), 1);
    @(negedge clk);
    convolution_enable = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " done drop"}, int'(done), 0);
  endtask

  initial begin
    rst_cnn = 1'b1;
    rst_weights = 1'b1;
    feature_WrEn = 1'b1;
    convolution_enable = 1'b1;
    feature_writeAddr = 1'b0;
    for (int i = 0; i < K*K; i++) weights_input[i] = 2'sd0;
    set_image(0, 0);
    #1;
    rst_cnn = 1'b0;
    rst_weights = 1'b0;
    #8;
    chk("reset done", int'(done), 0);
    set_exp_const(0, 0);
    check_maps("reset");
    #1;
    rst_cnn = 1'b1;
    rst_weights = 1'b1;

    // No weights loaded: all outputs zero
    set_image(0, 1);
    run("noweights", 0, 0, 100);
    set_exp_const(0, 0);
    check_maps("noweights");

    load_w(0, w0);
    load_w(1, w1);

    set_image(0, 1);
    run("ones", 0, 0, 100);
    set_exp_const(1, 9);
    check_maps("ones");

    set_image(0, -1);
    run("minus", 0, 0, 100);
    set_exp_const(-1, -9);
    check_maps("minus");

    set_image(1, 0);
    run("checker", 0, 0, 100);
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++) begin
        exp_m[0][r][c] = (((r + c) % 2) == 0) ? 9 : -9;
        exp_m[1][r][c] = (((r + c) % 2) == 0) ? 1 : -1;
      end
    check_maps("checker");

    set_image(2, 0);
    run("pixel", 0, 0, 100);
    set_exp_const(0, 0);
    for (int r = 3; r <= 5; r++)
      for (int c = 3; c <= 5; c++) begin
        exp_m[1][r][c] = 1;
        exp_m[0][r][c] = (((r + c) % 2) == 0) ? 1 : -1;
      end
    check_maps("pixel");
    chk("pixel map0[4][4]", int'(outfmap[0][4][4]), 1);
    chk("pixel map0[3][4]", int'(outfmap[0][3][4]), -1);
    chk("pixel map0[3][3]", int'(outfmap[0][3][3]), 1);

    // Five-cycle pause mid-run
    set_image(0, 1);
    run("pause", 30, 5, 105);
    set_exp_const(1, 9);
    check_maps("pause");

    // rst_cnn mid-run clears outputs immediately, keeps weights
    set_image(0, -1);
    @(negedge clk);
    convolution_enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_cnn = 1'b0;
    #1;
    chk("midrst done", int'(done), 0);
    set_exp_const(0, 0);
    check_maps("midrst");
    convolution_enable = 1'b1;
    @(negedge clk);
    rst_cnn = 1'b1;
    run("rerun", 0, 0, 100);
    set_exp_const(-1, -9);
    check_maps("rerun");

    // rst_weights leaves outputs alone, later run gives zeros
    @(negedge clk);
    rst_weights = 1'b0;
    #10;
    rst_weights = 1'b1;
    check_maps("wrst hold");
    run("wrst", 0, 0, 100);
    set_exp_const(0, 0);
    check_maps("wrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
